if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch / memory-access front end of the multicycle datapath.
//   - Holds the PC register and computes PC+4.
//   - Muxes the shared instruction/data memory address and write data.
//   - Contains the single-port unified memory with a registered read output.
//   - Sits between the control unit (mux selects, enables) and the IR/MDR/ALU stages.
// PARAMETERS
//   WIDTH   32   datapath width (PC, addresses, data)
//   ADDR_W  8    memory index bits; memory depth = 2**ADDR_W words
//   PC_INC  4    constant added to the PC by the adder
// PORTS
//   clock              in   1      system clock; all state updates on rising edge
//   reset              in   1      synchronous reset, active-high
//   entradaPC          in   WIDTH  next-PC value to load
//   PCescreve          in   1      PC write enable
//   ALu                in   WIDTH  ALU result; data-access address
//   data1              in   WIDTH  write-data candidate 0
//   data2              in   WIDTH  write-data candidate 1
//   c1                 in   1      address select: 0 = ALu, 1 = Pcsaida
//   c2                 in   1      write-data select: 0 = data1, 1 = data2
//   ler                in   1      memory read enable
//   escreve            in   1      memory write enable
//   Pcsaida            out  WIDTH  current PC (register)
//   saidaAdder         out  WIDTH  Pcsaida + PC_INC (combinational)
//   SaidaDadosInstruc  out  WIDTH  selected memory address (combinational)
//   writeDataMemWB     out  WIDTH  selected memory write data (combinational)
//   saidaMemoria       out  WIDTH  memory read data (register)
// BEHAVIOUR
//   Clock and reset
//   - One clock (clock). Reset is synchronous, active-high, and overrides all enables.
//   - Reset: Pcsaida <= 0, saidaMemoria <= 0.
//   - Memory contents are not reset; they are undefined until written.
//   PC
//   - Rising edge with PCescreve=1: Pcsaida <= entradaPC.
//   - Rising edge with PCescreve=0: Pcsaida holds.
//   - Latency: new PC is visible one edge after it is presented.
//   Adder
//   - saidaAdder = Pcsaida + PC_INC, mod 2**WIDTH; carry is discarded.
//   - Example: PC 0xFFFFFFFC -> 0x00000000.
//   Address mux
//   - SaidaDadosInstruc = c1 ? Pcsaida : ALu. Purely combinational.
//   Write-data mux
//   - writeDataMemWB = c2 ? data2 : data1. Purely combinational.
//   Memory
//   - 2**ADDR_W x WIDTH words, indexed by SaidaDadosInstruc[ADDR_W-1:0].
//   - Address is a word index; upper bits are ignored (address wraps modulo depth).
//   - Rising edge, escreve=1: mem[idx] <= writeDataMemWB.
//   - Rising edge, ler=1: saidaMemoria <= mem[idx].
//   - Rising edge, ler=0: saidaMemoria holds its last value.
//   - ler=1 and escreve=1 on the same edge, same index: saidaMemoria gets the OLD
//     word (read-before-write) and the new word is stored.
//   - Both enables low: memory and saidaMemoria unchanged.
//   - No handshake and no stall; every edge is independent.
// TESTING
//   1. reset=1 for one edge -> Pcsaida=0, saidaAdder=4, saidaMemoria=0.
//   2. entradaPC=0x80001234, PCescreve=1, one edge -> Pcsaida=0x80001234,
//      saidaAdder=0x80001238. Then PCescreve=0, entradaPC=0x5, one edge ->
//      Pcsaida unchanged.
//   3. c1=0, ALu=0x3, c2=0, data1=0xA5, data2=0x5A -> SaidaDadosInstruc=0x3,
//      writeDataMemWB=0xA5. Then c1=1, c2=1 -> SaidaDadosInstruc=Pcsaida,
//      writeDataMemWB=0x5A.
//   4. escreve=1, c1=0, c2=0, ALu=1..5 with data1=1..5 on five edges; then ler=1,
//      escreve=0, ALu=1..5 -> saidaMemoria=1..5, each one edge after its address.
//   5. ler=1, escreve=1, ALu=7, mem[7]=0x11, data1=0x22 -> saidaMemoria=0x11;
//      next read of index 7 returns 0x22. ler=0 -> saidaMemoria holds.
//   6. PC=0xFFFFFFFC -> saidaAdder=0; ALu=0x100+2 with ADDR_W=8 accesses index 2.

Source files
------------

// File: rtl/if_stage.sv
// Fetch/memory front end: PC register, PC adder, address and write-data
// muxes, and the unified single-port memory with a registered read port.
module if_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int PC_INC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entradaPC,
  input  logic             PCescreve,
  input  logic [WIDTH-1:0] ALu,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             c1,
  input  logic             c2,
  input  logic             ler,
  input  logic             escreve,
  output logic [WIDTH-1:0] Pcsaida,
  output logic [WIDTH-1:0] saidaAdder,
  output logic [WIDTH-1:0] SaidaDadosInstruc,
  output logic [WIDTH-1:0] writeDataMemWB,
  output logic [WIDTH-1:0] saidaMemoria
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_pc;
  logic [WIDTH-1:0]  r_rdata;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] w_idx;
  logic [WIDTH-1:0]  w_addr;
  logic [WIDTH-1:0]  w_wdata;

  assign w_addr  = c1 ? r_pc : ALu;
  assign w_wdata = c2 ? data2 : data1;
  // Word index; upper address bits wrap modulo depth
  assign w_idx   = w_addr[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= '0;
    end else if (PCescreve) begin
      r_pc <= entradaPC;
    end
  end

  // Read-before-write: a same-edge read returns the old word
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (ler) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && escreve) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign Pcsaida           = r_pc;
  assign saidaAdder        = r_pc + WIDTH'(PC_INC);
  assign SaidaDadosInstruc = w_addr;
  assign writeDataMemWB    = w_wdata;
  assign saidaMemoria      = r_rdata;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: PC, adder, muxes and memory read/write
// ordering, with a queue of expected read data popped after each read edge.
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] entradaPC;
  logic        PCescreve;
  logic [31:0] ALu;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        c1;
  logic        c2;
  logic        ler;
  logic        escreve;
  logic [31:0] Pcsaida;
  logic [31:0] saidaAdder;
  logic [31:0] SaidaDadosInstruc;
  logic [31:0] writeDataMemWB;
  logic [31:0] saidaMemoria;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [256];
  logic [31:0] sb_q [$];

  if_stage #(
    .WIDTH (32),
    .ADDR_W(8),
    .PC_INC(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .entradaPC        (entradaPC),
    .PCescreve        (PCescreve),
    .ALu              (ALu),
    .data1            (data1),
    .data2            (data2),
    .c1               (c1),
    .c2               (c2),
    .ler              (ler),
    .escreve          (escreve),
    .Pcsaida          (Pcsaida),
    .saidaAdder       (saidaAdder),
    .SaidaDadosInstruc(SaidaDadosInstruc),
    .writeDataMemWB   (writeDataMemWB),
    .saidaMemoria     (saidaMemoria)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk(tag, saidaMemoria, e);
    end
  endtask

  initial begin
    reset = 1'b1; entradaPC = '0; PCescreve = 1'b0;
    ALu = '0; data1 = '0; data2 = '0;
    c1 = 1'b0; c2 = 1'b0; ler = 1'b0; escreve = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_pc", Pcsaida, 32'h0);
    chk("rst_adder", saidaAdder, 32'h4);
    chk("rst_mem", saidaMemoria, 32'h0);

    entradaPC = 32'h8000_1234; PCescreve = 1'b1;
    step();
    chk("pc_load", Pcsaida, 32'h8000_1234);
    chk("pc_adder", saidaAdder, 32'h8000_1238);
    PCescreve = 1'b0; entradaPC = 32'h5;
    step();
    chk("pc_hold", Pcsaida, 32'h8000_1234);

    c1 = 1'b0; ALu = 32'h3; c2 = 1'b0;
    data1 = 32'hA5; data2 = 32'h5A;
    #1;
    chk("amux_alu", SaidaDadosInstruc, 32'h3);
    chk("wmux_d1", writeDataMemWB, 32'hA5);
    c1 = 1'b1; c2 = 1'b1;
    #1;
    chk("amux_pc", SaidaDadosInstruc, 32'h8000_1234);
    chk("wmux_d2", writeDataMemWB, 32'h5A);

    c1 = 1'b0; c2 = 1'b0; escreve = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ALu = i; data1 = i;
      step();
      model[i] = i;
    end
    escreve = 1'b0; ler = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ALu = i;
      sb_q.push_back(model[i]);
      step();
      sb_pop($sformatf("rd_%0d", i));
    end

    ler = 1'b0; escreve = 1'b1; ALu = 32'h7; data1 = 32'h11;
    step();
    model[7] = 32'h11;
    ler = 1'b1; data1 = 32'h22;
    sb_q.push_back(model[7]);
    step();
    model[7] = 32'h22;
    sb_pop("rbw_old");
    escreve = 1'b0;
    sb_q.push_back(model[7]);
    step();
    sb_pop("rbw_new");
    ler = 1'b0; ALu = 32'h1;
    step();
    chk("ler0_hold", saidaMemoria, 32'h22);

    entradaPC = 32'hFFFF_FFFC; PCescreve = 1'b1;
    step();
    PCescreve = 1'b0;
    chk("pc_wrap_pc", Pcsaida, 32'hFFFF_FFFC);
    chk("pc_wrap_add", saidaAdder, 32'h0);

    escreve = 1'b1; ALu = 32'h102; data1 = 32'hBEEF;
    step();
    model[2] = 32'hBEEF;
    c1 = 1'b1; data1 = 32'hCAFE;
    step();
    model[8'hFC] = 32'hCAFE;
    c1 = 1'b0; escreve = 1'b0; ler = 1'b1; ALu = 32'h2;
    sb_q.push_back(model[2]);
    step();
    sb_pop("addr_wrap");
    ALu = 32'hFC;
    sb_q.push_back(model[8'hFC]);
    step();
    sb_pop("pc_addr_wr");

    reset = 1'b1; PCescreve = 1'b1; entradaPC = 32'h40;
    escreve = 1'b1; ler = 1'b1; ALu = 32'h3; data1 = 32'h77;
    step();
    chk("rst_ovr_pc", Pcsaida, 32'h0);
    chk("rst_ovr_mem", saidaMemoria, 32'h0);
    reset = 1'b0; PCescreve = 1'b0; escreve = 1'b0;
    sb_q.push_back(model[3]);
    step();
    sb_pop("rst_no_wr");

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
